jk_bank_arbiter: RTL
====================

// Module: jk_bank_arbiter
// PURPOSE
//  Arbitrates a shared bank of WIDTH JK storage bits among N_REQ requesters.
//  Each requester presents a JK command (hold/reset/set/toggle) and a bit index.
//  A round-robin arbiter grants one requester at a time. The winning command is
//  applied to q/q_bar with clocked JK semantics: 11 toggles the bit, so q/q_bar
//  are always complementary. Sits between control FSMs and the JK flag/state bank.
// PARAMETERS
//  WIDTH  8  number of JK bits in the bank (>=2)
//  N_REQ  4  number of requesters (>=2)
//  IDX_W  3  index width; must equal $clog2(WIDTH)
// PORTS
//  clk    in   1            rising-edge clock
//  rst    in   1            synchronous, active-high reset
//  en     in   1            grant enable; when low no new grant is issued
//  req    in   N_REQ        per-requester request level, held until ack
//  cmd    in   2*N_REQ      {j,k} per requester, slice r = cmd[2r+1:2r]
//  idx    in   IDX_W*N_REQ  bit index per requester, slice r = idx[IDX_W*r +: IDX_W]
//  ack    out  N_REQ        one-cycle completion pulse to the granted requester
//  err    out  1            pulses with ack when idx >= WIDTH (bank unchanged)
//  busy   out  1            high while in state APPLY
//  gnt_id out  $clog2(N_REQ) id of the current or last granted requester
//  q      out  WIDTH        JK bank state
//  q_bar  out  WIDTH        always ~q
// BEHAVIOUR
//  Reset (sync): q=0, q_bar=all 1, ack=0, err=0, busy=0, gnt_id=0,
//   rr pointer=0, state=IDLE. Reset overrides any in-flight APPLY; that command is dropped.
//  FSM (2 states):
//   IDLE : if en && |eligible -> latch winner id, cmd, idx; gnt_id<=winner; -> APPLY.
//          eligible = req & ~ack. This masks the requester whose ack is high this cycle.
//   APPLY: busy=1; update bank; ack[gnt_id]<=1 and err<=(idx>=WIDTH) for exactly 1 cycle;
//          rr pointer <= gnt_id+1 (mod N_REQ); -> IDLE. APPLY always completes, even if en=0.
//  Bank update in APPLY at bit i=idx: 00 hold, 01 q[i]<=0, 10 q[i]<=1,
//   11 q[i]<=~q[i]. Other bits hold. q_bar<=~(next q) in the same edge.
//  Timing: req sampled in IDLE at edge n -> q and ack change at edge n+1 -> IDLE at n+1.
//   ack is visible during cycle n+1..n+2. Peak throughput is 1 command per 2 cycles.
//  Arbitration: round-robin starting at the rr pointer, searching upward with wrap.
//   The lowest id at or after the pointer wins. After reset the pointer is 0,
//   so requester 0 has first priority.
//  Requester rule: cmd/idx stable while req is high. Drop or re-raise req the cycle
//   after ack. A req still high after the masked cycle is treated as a new request.
//  Request withdrawn before grant: ignored, no ack. Withdrawn after grant: still acked.
//  idx >= WIDTH (non-power-of-2 WIDTH): no bank change, ack+err pulse,
//   rr pointer advances normally.
//  en low in IDLE: state holds and the pointer does not move.
// STRUCTURE
//  Shared include jk_bank_defs.vh: JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10,
//   JK_TGL=2'b11; state encodings ST_IDLE/ST_APPLY.
//  Sub-module jk_rr_arbiter (N_REQ): inputs eligible and pointer; outputs one-hot
//   grant and binary id; purely combinational. Reusable by other bank controllers.
//  Top level holds the FSM, latched cmd/idx, rr pointer and the q register bank.
// TESTING
//  1 Reset: drive rst=1 mid-APPLY (req0 SET idx3) -> next edge q=0x00, q_bar=0xFF,
//    ack=0, busy=0; no late ack.
//  2 Single ops: req1 SET idx2 -> q=0x04, ack[1] 1 cycle after grant; then
//    TGL idx2 -> 0x00; TGL idx2 -> 0x04; RST idx2 -> 0x00; HOLD -> unchanged.
//    Check q_bar==~q every cycle.
//  3 Round robin: req=4'b1111 held continuously (each re-raised after ack) ->
//    grant order 0,1,2,3,0; each ack spaced 2 cycles apart.
//  4 Masking: req0 held through its ack cycle -> no double grant in that cycle;
//    if req1 is pending, req1 is granted next.
//  5 en gating: en=0 with req2 pending -> no grant and busy=0 for 5 cycles;
//    en=1 -> grant 2 on next edge. en dropped during APPLY -> ack still issued.
//  6 Out of range: WIDTH=6, IDX_W=3, req3 SET idx7 -> ack[3]=1, err=1, q unchanged;
//    pointer moves to 0.

Source files
------------

// File: rtl/jk_bank_arbiter_pkg.sv
// Shared definitions for the JK bank arbiter: JK command codes, FSM states
// and the single-bit JK next-state function.
package jk_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_e;

    function automatic logic jkNext(input jk_cmd_e cmd, input logic q);
        case (cmd)
            JK_RST:  jkNext = 1'b0;
            JK_SET:  jkNext = 1'b1;
            JK_TGL:  jkNext = ~q;
            default: jkNext = q;
        endcase
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester/bank bus of the JK bank arbiter; the requester side is the master,
// the arbiter is the slave.
interface jk_bank_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int IDX_W = 3
);
    logic                       en;
    logic [N_REQ-1:0]           req;
    logic [2*N_REQ-1:0]         cmd;
    logic [IDX_W*N_REQ-1:0]     idx;
    logic [N_REQ-1:0]           ack;
    logic                       err;
    logic                       busy;
    logic [$clog2(N_REQ)-1:0]   gnt_id;
    logic [WIDTH-1:0]           q;
    logic [WIDTH-1:0]           q_bar;

    modport master (
        output en, req, cmd, idx,
        input  ack, err, busy, gnt_id, q, q_bar
    );

    modport slave (
        input  en, req, cmd, idx,
        output ack, err, busy, gnt_id, q, q_bar
    );
endinterface

// File: rtl/jk_rr_arbiter.sv
// Combinational round-robin picker: the lowest eligible id at or after the
// pointer wins, searching upward with wrap-around.
module jk_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_eligible,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_id,
    output logic             o_valid
);

    always_comb begin
        int  cand;
        logic found;
        o_grant = '0;
        o_id    = '0;
        found   = 1'b0;
        cand    = 0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = int'(i_ptr) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && i_eligible[cand]) begin
                found         = 1'b1;
                o_grant[cand] = 1'b1;
                o_id          = ID_W'(cand);
            end
        end
        o_valid = found;
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that applies one requester's JK command per two cycles
// to a shared bank of JK bits (q/q_bar kept complementary).
module jk_bank_arbiter
    import jk_bank_arbiter_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_REQ = 4,
    parameter  int IDX_W = 3,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input logic               i_clk,
    input logic               i_rst,
    jk_bank_arbiter_if.slave  bus
);

    state_e           r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_gntId;
    jk_cmd_e          r_cmd;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qBar;
    logic [N_REQ-1:0] r_ack;
    logic             r_err;
    logic             r_busy;

    logic [N_REQ-1:0] w_eligible;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_winId;
    logic             w_valid;
    jk_cmd_e          w_cmd;
    logic [IDX_W-1:0] w_idx;
    logic             w_inRange;
    logic [WIDTH-1:0] w_qNext;

    // A requester being acked this cycle must not win again on the same edge.
    assign w_eligible = bus.req & ~r_ack;

    jk_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_id       (w_winId),
        .o_valid    (w_valid)
    );

    always_comb begin
        w_cmd = JK_HOLD;
        w_idx = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (w_grant[r]) begin
                w_cmd = jk_cmd_e'(bus.cmd[2*r +: 2]);
                w_idx = bus.idx[IDX_W*r +: IDX_W];
            end
        end
    end

    assign w_inRange = (int'(r_idx) < WIDTH);

    always_comb begin
        w_qNext = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(r_idx) == i) begin
                w_qNext[i] = jkNext(r_cmd, r_q[i]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gntId <= '0;
            r_cmd   <= JK_HOLD;
            r_idx   <= '0;
            r_q     <= '0;
            r_qBar  <= '1;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= '0;
                    r_err <= 1'b0;
                    if (bus.en && w_valid) begin
                        r_gntId <= w_winId;
                        r_cmd   <= w_cmd;
                        r_idx   <= w_idx;
                        r_busy  <= 1'b1;
                        r_state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_q     <= w_qNext;
                    r_qBar  <= ~w_qNext;
                    r_ack   <= N_REQ'(1) << r_gntId;
                    r_err   <= ~w_inRange;
                    r_ptr   <= (r_gntId == ID_W'(N_REQ - 1)) ? '0 : r_gntId + 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack    = r_ack;
    assign bus.err    = r_err;
    assign bus.busy   = r_busy;
    assign bus.gnt_id = r_gntId;
    assign bus.q      = r_q;
    assign bus.q_bar  = r_qBar;

endmodule
